// File: rtl/parser_pkt_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// parser_pkt_tx : serializes rule-config and PHV requests into contiguous
//                 134-bit parser ingress bursts.
// Revision: 1.0
// ----------------------------------------------------------------------------
module parser_pkt_tx #(
  parameter int MIN_GAP = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic           cfg_rd,
  input  logic [1:0]     cfg_stage,
  input  logic [2:0]     cfg_addr,
  input  logic [176:0]   cfg_data,
  input  logic           phv_valid,
  output logic           phv_ready,
  input  logic [1023:0]  phv_data,
  input  logic           tx_ready,
  output logic           tx_data_wr,
  output logic [133:0]   tx_data,
  output logic           tx_data_valid_wr,
  output logic           tx_data_valid,
  output logic [15:0]    cnt_cfg,
  output logic [15:0]    cnt_phv
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_beat;
  logic [3:0]      r_gap;
  logic            r_is_cfg;
  logic            r_cfg_rd;
  logic [1:0]      r_cfg_stage;
  logic [2:0]      r_cfg_addr;
  logic [176:0]    r_cfg_data;
  logic [1023:0]   r_phv;
  logic [15:0]     r_cnt_cfg;
  logic [15:0]     r_cnt_phv;

  logic            w_can_accept;
  logic            w_acc_cfg;
  logic            w_acc_phv;
  logic            w_last;
  logic [3:0]      w_last_idx;
  logic [1:0]      w_flag;
  logic [127:0]    w_payload;

  assign w_can_accept = rst_n & (r_state == IDLE) & tx_ready;
  assign cfg_ready    = w_can_accept;
  assign phv_ready    = w_can_accept & ~cfg_valid;
  assign w_acc_cfg    = cfg_valid & cfg_ready;
  assign w_acc_phv    = phv_valid & phv_ready;
  assign w_last_idx   = r_is_cfg ? 4'd2 : 4'd8;
  assign w_last       = (r_state == SEND) && (r_beat == w_last_idx);

  assign cnt_cfg      = r_cnt_cfg;
  assign cnt_phv      = r_cnt_phv;
  assign tx_data      = {w_flag, 4'b0000, w_payload};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Beat contents are decoded from the state so a reset clears them at once.
  always_comb begin
    w_next           = r_state;
    w_flag           = 2'b00;
    w_payload        = '0;
    tx_data_wr       = 1'b0;
    tx_data_valid_wr = 1'b0;
    tx_data_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc_cfg || w_acc_phv) w_next = SEND;
      end
      SEND: begin
        tx_data_wr = 1'b1;
        if (r_beat == 4'd0) begin
          w_flag = 2'b01;
          if (r_is_cfg)
            w_payload = {102'b0, r_cfg_stage, 5'b0, r_cfg_addr, 7'b0, r_cfg_rd, 7'b0, 1'b1};
        end else if (r_is_cfg) begin
          w_payload = (r_beat == 4'd1) ? {79'b0, r_cfg_data[176:128]} : r_cfg_data[127:0];
        end else begin
          w_payload = r_phv[1023:896];
        end
        if (w_last) begin
          w_flag           = 2'b10;
          tx_data_valid_wr = 1'b1;
          tx_data_valid    = 1'b1;
          w_next           = (MIN_GAP > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (r_gap == 4'd0) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat      <= '0;
      r_gap       <= '0;
      r_is_cfg    <= 1'b0;
      r_cfg_rd    <= 1'b0;
      r_cfg_stage <= '0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_phv       <= '0;
      r_cnt_cfg   <= '0;
      r_cnt_phv   <= '0;
    end else begin
      if (w_acc_cfg) begin
        r_is_cfg    <= 1'b1;
        r_cfg_rd    <= cfg_rd;
        r_cfg_stage <= cfg_stage;
        r_cfg_addr  <= cfg_addr;
        r_cfg_data  <= cfg_data;
        r_beat      <= '0;
      end else if (w_acc_phv) begin
        r_is_cfg    <= 1'b0;
        r_phv       <= phv_data;
        r_beat      <= '0;
      end
      if (r_state == SEND) begin
        r_beat <= r_beat + 4'd1;
        // PHV words leave MSB-first, so shift the next word into the top slot.
        if (!r_is_cfg && (r_beat != 4'd0)) r_phv <= {r_phv[895:0], 128'b0};
        if (w_last) begin
          r_gap <= 4'(MIN_GAP - 1);
          if (r_is_cfg) r_cnt_cfg <= r_cnt_cfg + 16'd1;
          else          r_cnt_phv <= r_cnt_phv + 16'd1;
        end
      end
      if (r_state == GAP) r_gap <= r_gap - 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parser_pkt_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_parser_pkt_tx : scoreboard bench for parser_pkt_tx.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_parser_pkt_tx;

  typedef struct packed {
    int                 acc;
    int                 n;
    logic               is_cfg;
    logic [8:0][133:0]  beat;
  } pkt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           cfg_valid = 1'b0, cfg_rd = 1'b0, phv_valid = 1'b0, tx_ready = 1'b0;
  logic [1:0]     cfg_stage = '0;
  logic [2:0]     cfg_addr = '0;
  logic [176:0]   cfg_data = '0;
  logic [1023:0]  phv_data = '0;
  logic           cfg_ready, phv_ready, tx_data_wr, tx_data_valid_wr, tx_data_valid;
  logic [133:0]   tx_data;
  logic [15:0]    cnt_cfg, cnt_phv;

  parser_pkt_tx #(.MIN_GAP(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_rd(cfg_rd),
    .cfg_stage(cfg_stage), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .phv_valid(phv_valid), .phv_ready(phv_ready), .phv_data(phv_data),
    .tx_ready(tx_ready), .tx_data_wr(tx_data_wr), .tx_data(tx_data),
    .tx_data_valid_wr(tx_data_valid_wr), .tx_data_valid(tx_data_valid),
    .cnt_cfg(cnt_cfg), .cnt_phv(cnt_phv)
  );

  // Second instance with a forced inter-packet gap.
  logic           g_phv_valid = 1'b0, g_tx_ready = 1'b1;
  logic [1023:0]  g_phv_data = '0;
  logic           g_cfg_ready, g_phv_ready, g_wr, g_vwr, g_v;
  logic [133:0]   g_data;
  logic [15:0]    g_cnt_cfg, g_cnt_phv;

  parser_pkt_tx #(.MIN_GAP(3)) dut_gap (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(1'b0), .cfg_ready(g_cfg_ready), .cfg_rd(1'b0),
    .cfg_stage(2'b00), .cfg_addr(3'b000), .cfg_data(177'b0),
    .phv_valid(g_phv_valid), .phv_ready(g_phv_ready), .phv_data(g_phv_data),
    .tx_ready(g_tx_ready), .tx_data_wr(g_wr), .tx_data(g_data),
    .tx_data_valid_wr(g_vwr), .tx_data_valid(g_v),
    .cnt_cfg(g_cnt_cfg), .cnt_phv(g_cnt_phv)
  );

  int   n_cmp = 0, n_err = 0;
  int   cyc = 0;
  int   busy_until = -1;
  int   mdl_cfg = 0, mdl_phv = 0;
  int   beats_seen = 0;
  int   bi = 0;
  bit   in_pkt = 0, cnt_pending = 0;
  pkt_t cur;
  pkt_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference packet images built straight from the beat layout rules.
  function automatic pkt_t mk_cfg(int acc, logic rd, logic [1:0] st, logic [2:0] ad, logic [176:0] d);
    pkt_t p;
    p = '0;
    p.acc = acc; p.n = 3; p.is_cfg = 1'b1;
    p.beat[0][133:132] = 2'b01;
    p.beat[0][0] = 1'b1;
    p.beat[0][8] = rd;
    p.beat[0][18:16] = ad;
    p.beat[0][25:24] = st;
    p.beat[1][48:0] = d[176:128];
    p.beat[2][133:132] = 2'b10;
    p.beat[2][127:0] = d[127:0];
    return p;
  endfunction

  function automatic pkt_t mk_phv(int acc, logic [1023:0] ph);
    pkt_t p;
    p = '0;
    p.acc = acc; p.n = 9; p.is_cfg = 1'b0;
    p.beat[0][133:132] = 2'b01;
    for (int k = 1; k <= 8; k++) p.beat[k][127:0] = ph[1151 - 128*k -: 128];
    p.beat[8][133:132] = 2'b10;
    return p;
  endfunction

  task automatic flush_model();
    exp_q.delete();
    in_pkt = 0; cnt_pending = 0; bi = 0;
    mdl_cfg = 0; mdl_phv = 0;
    busy_until = -1;
  endtask

  // Monitor: ready model, beat scoreboard, burst contiguity, counters.
  initial begin
    logic exp_rdy;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_rdy = tx_ready && (cyc > busy_until);
        chk("cfg_ready", 134'(cfg_ready), 134'(exp_rdy));
        chk("phv_ready", 134'(phv_ready), 134'(exp_rdy && !cfg_valid));
        if (cnt_pending) begin
          chk("cnt_cfg", 134'(cnt_cfg), 134'(16'(mdl_cfg)));
          chk("cnt_phv", 134'(cnt_phv), 134'(16'(mdl_phv)));
          cnt_pending = 0;
        end
        if (tx_data_wr) begin
          beats_seen++;
          if (!in_pkt) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_beat", 134'(1), 134'(0));
            end else begin
              cur = exp_q.pop_front();
              in_pkt = 1; bi = 0;
              chk("hdr_latency", 134'(cyc), 134'(cur.acc + 1));
            end
          end
          if (in_pkt) begin
            chk("beat_data", tx_data, cur.beat[bi]);
            chk("eop_flags", 134'({tx_data_valid_wr, tx_data_valid}), (bi == cur.n - 1) ? 134'(3) : 134'(0));
            bi++;
            if (bi == cur.n) begin
              in_pkt = 0;
              if (cur.is_cfg) mdl_cfg++; else mdl_phv++;
              cnt_pending = 1;
            end
          end
        end else begin
          if (in_pkt) begin
            chk("burst_hole", 134'(1), 134'(0));
            in_pkt = 0;
          end
          chk("idle_outputs", {tx_data_valid_wr, tx_data_valid, tx_data[131:0]}, 134'(0));
        end
      end
    end
  end

  // One cycle of driving; records any handshake into the scoreboard.
  task automatic step(output bit tc, output bit tp);
    tc = 0; tp = 0;
    @(negedge clk); #1;
    if (cfg_valid && cfg_ready) begin
      exp_q.push_back(mk_cfg(cyc, cfg_rd, cfg_stage, cfg_addr, cfg_data));
      busy_until = cyc + 3;
      tc = 1;
    end else if (phv_valid && phv_ready) begin
      exp_q.push_back(mk_phv(cyc, phv_data));
      busy_until = cyc + 9;
      tp = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_take(input bit want_cfg);
    bit tc, tp;
    int k;
    for (k = 0; k < 200; k++) begin
      step(tc, tp);
      if (want_cfg ? tc : tp) break;
    end
    if (k == 200) chk("accept_timeout", 134'(1), 134'(0));
    if (want_cfg) cfg_valid = 0; else phv_valid = 0;
  endtask

  task automatic drain();
    bit tc, tp;
    int k;
    for (k = 0; k < 100; k++) begin
      if (exp_q.size() == 0 && !in_pkt) break;
      step(tc, tp);
    end
    if (k == 100) chk("drain_timeout", 134'(1), 134'(0));
    step(tc, tp);
    step(tc, tp);
  endtask

  task automatic rand_cfg();
    logic [191:0] t;
    for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom;
    cfg_data  = t[176:0];
    cfg_rd    = 1'($urandom);
    cfg_stage = 2'($urandom);
    cfg_addr  = 3'($urandom);
  endtask

  task automatic rand_phv();
    for (int i = 0; i < 32; i++) phv_data[i*32 +: 32] = $urandom;
  endtask

  // Back-to-back PHVs through the MIN_GAP=3 instance.
  initial begin
    int  run, idle;
    bit  counting;
    run = 0; idle = 0; counting = 0;
    for (int i = 0; i < 32; i++) g_phv_data[i*32 +: 32] = $urandom;
    @(posedge rst_n);
    @(posedge clk); #1;
    g_phv_valid = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (g_wr) begin
        if (counting) begin
          chk("gap_idle_cycles", 134'(idle), 134'(4));
          counting = 0;
        end
        run++;
        if (g_vwr) begin
          chk("gap_burst_len", 134'(run), 134'(9));
          run = 0; idle = 0; counting = 1;
        end
      end else if (counting) begin
        idle++;
      end
    end
    g_phv_valid = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    bit tc, tp;
    int b0;

    // Reset with requests pending: nothing may be accepted or driven.
    cfg_valid = 1; phv_valid = 1; tx_ready = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_cfg_ready", 134'(cfg_ready), 134'(0));
      chk("rst_phv_ready", 134'(phv_ready), 134'(0));
      chk("rst_outputs", {tx_data_wr, tx_data_valid_wr, tx_data_valid, tx_data[130:0]}, 134'(0));
      chk("rst_counters", 134'({cnt_cfg, cnt_phv}), 134'(0));
    end
    cfg_valid = 0; phv_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;

    // Config write, stage 2, addr 5.
    cfg_rd = 0; cfg_stage = 2'd2; cfg_addr = 3'd5;
    cfg_data = 177'h1_23456789ABCDEF01_23456789ABCDEF01_23456789ABCD;
    cfg_valid = 1;
    wait_take(1);
    drain();

    // PHV with distinctive first and last words.
    rand_phv();
    phv_data[1023:896] = {32{4'hA}};
    phv_data[127:0]    = {32{4'h5}};
    phv_valid = 1;
    wait_take(0);
    drain();

    // Both requests at once: config first, PHV right after.
    b0 = beats_seen;
    rand_cfg(); rand_phv();
    cfg_valid = 1; phv_valid = 1;
    wait_take(1);
    wait_take(0);
    drain();
    chk("both_total_beats", 134'(beats_seen - b0), 134'(12));

    // tx_ready low blocks accepts; dropping it mid-burst must not stall.
    rand_cfg(); rand_phv();
    tx_ready = 0; cfg_valid = 1; phv_valid = 1;
    repeat (5) begin
      step(tc, tp);
      chk("blocked_accept", 134'({tc, tp}), 134'(0));
    end
    tx_ready = 1;
    wait_take(1);
    wait_take(0);
    tx_ready = 0;
    drain();
    tx_ready = 1;

    // Randomized traffic with a wandering tx_ready.
    for (int c = 0; c < 400; c++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if (!cfg_valid && $urandom_range(0, 5) == 0) begin rand_cfg(); cfg_valid = 1; end
      if (!phv_valid && $urandom_range(0, 3) == 0) begin rand_phv(); phv_valid = 1; end
      step(tc, tp);
      if (tc) cfg_valid = 0;
      if (tp) phv_valid = 0;
    end
    cfg_valid = 0; phv_valid = 0; tx_ready = 1;
    drain();

    // Reset while PHV beat 4 is on the wire.
    rand_phv();
    phv_valid = 1;
    wait_take(0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 0;
    flush_model();
    #1;
    chk("midrst_tx_wr", 134'(tx_data_wr), 134'(0));
    chk("midrst_tx_data", tx_data, 134'(0));
    chk("midrst_eop", 134'({tx_data_valid_wr, tx_data_valid}), 134'(0));
    chk("midrst_counters", 134'({cnt_cfg, cnt_phv}), 134'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    rand_cfg();
    cfg_valid = 1;
    wait_take(1);
    drain();
    chk("post_rst_cnt_cfg", 134'(cnt_cfg), 134'(1));
    chk("post_rst_cnt_phv", 134'(cnt_phv), 134'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
